riscv_hazard_unit_mc: RTL

//  Hazard and stall controller for the 5-stage pipeline. Adds a multi-cycle multiply/divide unit (MDU) and a data memory with a ready handshake.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/riscv_hazard_unit_mc_if.sv | 51 +++++
 rtl/riscv_mdu_seq.sv | 81 ++++++++
 rtl/riscv_hazard_unit_mc.sv | 76 +++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the hazard/stall controller.
//   FWD_*        forwarding-select encodings for ForwardAE/ForwardBE
//   mdu_state_t  MDU sequencer states
package riscv_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from W-stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from M-stage ALU result

  typedef enum logic {
    IDLE,
    BUSY
  } mdu_state_t;

endpackage

// File: rtl/riscv_hazard_unit_mc_if.sv
// Bundle between the pipeline datapath and the hazard unit.
//   master : datapath side (drives register addresses/status, receives controls)
//   slave  : hazard unit side
interface riscv_hazard_unit_mc_if #(
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic [REG_AW-1:0] RdM;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              ResultSrcE0;
  logic              PCSrcE;
  logic              MduStartE;
  logic              MemReqM;
  logic              MemReadyM;

  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              StallM;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              FlushW;
  logic              MduDoneE;
  logic              MduBusy;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
           MduStartE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, MduDoneE, MduBusy
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
           MduStartE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, MduDoneE, MduBusy
  );

endinterface

// File: rtl/riscv_mdu_seq.sv
// MDU sequencer: holds the E stage for MDU_LATENCY cycles per op and
// produces the one-cycle completion pulse.
//   clk, rst      clock, asynchronous active-low reset
//   i_start       E instruction is an MDU op (level)
//   i_mem_stall   data memory is holding M this cycle
//   o_mdu_stall   MDU needs E held this cycle
//   o_done        result valid, E may advance (1-cycle pulse)
//   o_busy        sequencer not IDLE
module riscv_mdu_seq
  import riscv_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_mem_stall,
  output logic o_mdu_stall,
  output logic o_done,
  output logic o_busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MDU_LATENCY - 1);

  mdu_state_t       r_state;
  mdu_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_start;

  // Start is masked while reset is asserted so no stall leaks out of a
  // core that is being reset with an MDU op still sitting in E.
  assign w_start = i_start & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_mdu_stall = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          o_mdu_stall = 1'b1;
          w_state_nxt = BUSY;
          w_cnt_nxt   = LAT_M1;
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          // Counting continues under a memory stall.
          o_mdu_stall = 1'b1;
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end else if (i_mem_stall) begin
          // Result ready but E cannot advance; defer the done pulse.
          o_mdu_stall = 1'b1;
        end else begin
          o_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy = (r_state == BUSY);

endmodule

// File: rtl/riscv_hazard_unit_mc.sv
// Hazard and stall controller for the 5-stage pipeline with a multi-cycle
// MDU and a data memory with a ready handshake.
//   clk, rst  clock, asynchronous active-low reset
//   hz        hazard bundle (slave side): register addresses and pipeline
//             status in; forwarding selects, per-stage stall/flush, MDU
//             done/busy out
module riscv_hazard_unit_mc
  import riscv_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  riscv_hazard_unit_mc_if.slave  hz
);

  logic w_lw_stall;
  logic w_mem_stall;
  logic w_mdu_stall;
  logic w_mdu_done;
  logic w_mdu_busy;

  function automatic logic [1:0] fwd_sel(
    input logic              regwrite_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              regwrite_w,
    input logic [REG_AW-1:0] rd_w,
    input logic [REG_AW-1:0] rs
  );
    if (regwrite_m && (rd_m != '0) && (rd_m == rs))
      return FWD_MEM;
    else if (regwrite_w && (rd_w != '0) && (rd_w == rs))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

  always_comb begin
    hz.ForwardAE = fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs1E);
    hz.ForwardBE = fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs2E);
  end

  assign w_lw_stall  = hz.ResultSrcE0 && (hz.RdE != '0) &&
                       ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign w_mem_stall = hz.MemReqM & ~hz.MemReadyM;

  riscv_mdu_seq #(
    .MDU_LATENCY (MDU_LATENCY),
    .CNT_W       (CNT_W)
  ) u_mdu_seq (
    .clk         (clk),
    .rst         (rst),
    .i_start     (hz.MduStartE),
    .i_mem_stall (w_mem_stall),
    .o_mdu_stall (w_mdu_stall),
    .o_done      (w_mdu_done),
    .o_busy      (w_mdu_busy)
  );

  always_comb begin
    hz.StallF   = w_lw_stall | w_mdu_stall | w_mem_stall;
    hz.StallD   = w_lw_stall | w_mdu_stall | w_mem_stall;
    hz.StallE   = w_mdu_stall | w_mem_stall;
    hz.StallM   = w_mem_stall;
    // A held E stage keeps the branch; its redirect flushes once E moves.
    hz.FlushD   = hz.PCSrcE & ~hz.StallE;
    hz.FlushE   = (w_lw_stall | hz.PCSrcE) & ~hz.StallE;
    hz.FlushM   = w_mdu_stall & ~w_mem_stall;
    hz.FlushW   = w_mem_stall;
    hz.MduDoneE = w_mdu_done;
    hz.MduBusy  = w_mdu_busy;
  end

endmodule
